// File: rtl/mmu_pkg.sv
// Shared MMU definitions: TLB op codes, sequencer state encoding and
// the layout of the packed EntryHi/EntryLo0/EntryLo1/PageMask word.
package mmu_pkg;

  localparam int ENTRY_W = 86;

  localparam int PAGEMASK_LSB = 0;
  localparam int PAGEMASK_W   = 16;
  localparam int ENTRYLO1_LSB = PAGEMASK_LSB + PAGEMASK_W;
  localparam int ENTRYLO1_W   = 19;
  localparam int ENTRYLO0_LSB = ENTRYLO1_LSB + ENTRYLO1_W;
  localparam int ENTRYLO0_W   = 19;
  localparam int ENTRYHI_LSB  = ENTRYLO0_LSB + ENTRYLO0_W;
  localparam int ENTRYHI_W    = ENTRY_W - ENTRYHI_LSB;

  localparam logic [1:0] TLBOP_P  = 2'b00;
  localparam logic [1:0] TLBOP_R  = 2'b01;
  localparam logic [1:0] TLBOP_WI = 2'b10;
  localparam logic [1:0] TLBOP_WR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } tlb_state_e;

  function automatic logic tlbop_is_write(input logic [1:0] op);
    return (op == TLBOP_WI) || (op == TLBOP_WR);
  endfunction

endpackage

// File: rtl/tlb_random_counter.sv
// CP0 Random register: free-running down-counter that wraps to the top
// entry once it reaches Wired, and reloads whenever Wired is written.
module tlb_random_counter #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(TLB_ENTRIES - 1);

  logic [IDX_W-1:0] random_q, random_d;

  always_comb begin
    random_d = random_q - 1'b1;
    if (wired_we || (random_q <= wired)) begin
      random_d = TOP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      random_q <= TOP;
    end else begin
      random_q <= random_d;
    end
  end

  assign random = random_q;

endmodule

// File: rtl/tlb_op_sequencer.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR onto the MMU TLB: stalls EX for the
// op, drives one-cycle strobes and returns probe/read results to CP0.
module tlb_op_sequencer
  import mmu_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int ENTRY_W     = mmu_pkg::ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_valid,
  input  logic [1:0]               op_code,
  input  logic                     flush,
  output logic                     stall_o,
  input  logic [IDX_W-1:0]         cp0_index,
  input  logic [IDX_W-1:0]         cp0_wired,
  input  logic                     cp0_wired_we,
  input  logic [ENTRY_W-1:0]       cp0_entry,
  output logic [IDX_W-1:0]         random_o,
  output logic [ENTRY_W+IDX_W-1:0] tlb_config,
  output logic                     tlbwi,
  output logic                     tlbp,
  input  logic [31:0]              tlbp_result,
  output logic [IDX_W-1:0]         tlb_rd_index,
  input  logic [ENTRY_W-1:0]       tlb_rd_data,
  output logic                     index_we,
  output logic [31:0]              probe_index_o,
  output logic                     entry_we,
  output logic [ENTRY_W-1:0]       entry_o
);

  tlb_state_e               state_q, state_d;
  logic [1:0]               op_q, op_d;
  logic [ENTRY_W+IDX_W-1:0] config_q, config_d;
  logic                     tlbwi_q, tlbwi_d;
  logic                     tlbp_q, tlbp_d;
  logic [IDX_W-1:0]         rd_index_q, rd_index_d;
  logic                     index_we_q, index_we_d;
  logic [31:0]              probe_q, probe_d;
  logic                     entry_we_q, entry_we_d;
  logic [ENTRY_W-1:0]       entry_q, entry_d;
  logic [IDX_W-1:0]         idx_sel;
  logic                     accept;

  tlb_random_counter #(
    .TLB_ENTRIES(TLB_ENTRIES),
    .IDX_W      (IDX_W)
  ) u_random (
    .clk     (clk),
    .rst     (rst),
    .wired   (cp0_wired),
    .wired_we(cp0_wired_we),
    .random  (random_o)
  );

  assign accept  = (state_q == S_IDLE) && op_valid && !flush;
  // TLBWR must use the Random value seen in the accept cycle.
  assign idx_sel = (op_code == TLBOP_WR) ? random_o : cp0_index;

  // Strobes are computed one state early so they are registered outputs
  // that are high exactly while the FSM sits in EXEC (or DONE).
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    config_d   = config_q;
    rd_index_d = rd_index_q;
    probe_d    = probe_q;
    entry_d    = entry_q;
    tlbwi_d    = 1'b0;
    tlbp_d     = 1'b0;
    index_we_d = 1'b0;
    entry_we_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = op_code;
          config_d = {idx_sel, cp0_entry};
          tlbwi_d  = tlbop_is_write(op_code);
          tlbp_d   = (op_code == TLBOP_P);
          if (op_code == TLBOP_R) begin
            rd_index_d = idx_sel;
          end
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_WAIT;
      S_WAIT: begin
        if (op_q == TLBOP_P) begin
          probe_d    = tlbp_result;
          index_we_d = 1'b1;
        end
        if (op_q == TLBOP_R) begin
          entry_d    = tlb_rd_data;
          entry_we_d = 1'b1;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= TLBOP_P;
      config_q   <= '0;
      tlbwi_q    <= 1'b0;
      tlbp_q     <= 1'b0;
      rd_index_q <= '0;
      index_we_q <= 1'b0;
      probe_q    <= '0;
      entry_we_q <= 1'b0;
      entry_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      config_q   <= config_d;
      tlbwi_q    <= tlbwi_d;
      tlbp_q     <= tlbp_d;
      rd_index_q <= rd_index_d;
      index_we_q <= index_we_d;
      probe_q    <= probe_d;
      entry_we_q <= entry_we_d;
      entry_q    <= entry_d;
    end
  end

  assign stall_o       = accept || (state_q == S_EXEC) || (state_q == S_WAIT);
  assign tlb_config    = config_q;
  assign tlbwi         = tlbwi_q;
  assign tlbp          = tlbp_q;
  assign tlb_rd_index  = rd_index_q;
  assign index_we      = index_we_q;
  assign probe_index_o = probe_q;
  assign entry_we      = entry_we_q;
  assign entry_o       = entry_q;

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Self-checking bench for tlb_op_sequencer: directed op sequences with a
// scoreboard of expected TLB writes and CP0 write-backs.
module tb_tlb_op_sequencer;

  localparam int N  = 16;
  localparam int IW = 4;
  localparam int EW = 86;

  localparam logic [1:0] K_WR = 2'd0;
  localparam logic [1:0] K_P  = 2'd1;
  localparam logic [1:0] K_R  = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_valid = 1'b0;
  logic [1:0]    op_code = 2'b00;
  logic          flush = 1'b0;
  logic          stall_o;
  logic [IW-1:0] cp0_index = '0;
  logic [IW-1:0] cp0_wired = '0;
  logic          cp0_wired_we = 1'b0;
  logic [EW-1:0] cp0_entry = '0;
  logic [IW-1:0] random_o;
  logic [EW+IW-1:0] tlb_config;
  logic          tlbwi, tlbp;
  logic [31:0]   tlbp_result = '0;
  logic [IW-1:0] tlb_rd_index;
  logic [EW-1:0] tlb_rd_data = '0;
  logic          index_we, entry_we;
  logic [31:0]   probe_index_o;
  logic [EW-1:0] entry_o;

  typedef struct packed {
    logic [1:0]   kind;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic [IW-1:0] rand_model;

  tlb_op_sequencer dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .flush(flush), .stall_o(stall_o), .cp0_index(cp0_index),
    .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we),
    .cp0_entry(cp0_entry), .random_o(random_o), .tlb_config(tlb_config),
    .tlbwi(tlbwi), .tlbp(tlbp), .tlbp_result(tlbp_result),
    .tlb_rd_index(tlb_rd_index), .tlb_rd_data(tlb_rd_data),
    .index_we(index_we), .probe_index_o(probe_index_o),
    .entry_we(entry_we), .entry_o(entry_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference Random register, straight from its architectural definition.
  always @(posedge clk or posedge rst) begin
    if (rst) rand_model <= IW'(N - 1);
    else if (cp0_wired_we || rand_model <= cp0_wired) rand_model <= IW'(N - 1);
    else rand_model <= rand_model - 1'b1;
  end

  task automatic sb_pop(input logic [1:0] kind, input logic [127:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_unexpected", 128'(exp_q.size()), 128'd1);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 128'(kind), 128'(e.kind));
      check("sb_data", obs, e.data);
      $display("txn kind=%0d data=%0h", kind, obs);
    end
  endtask

  always @(negedge clk) begin
    check("random_model", 128'(random_o), 128'(rand_model));
    check("strobe_excl", 128'(tlbwi & tlbp), 128'd0);
    if (tlbwi)    sb_pop(K_WR, 128'(tlb_config));
    if (index_we) sb_pop(K_P, 128'(probe_index_o));
    if (entry_we) sb_pop(K_R, 128'(entry_o));
  end

  // Issue one op in the current (IDLE) cycle T and walk it to completion.
  task automatic run_op(input logic [1:0] code, input logic [IW-1:0] idx,
                        input logic [EW-1:0] ent, input logic [31:0] res,
                        input logic [EW-1:0] rd, input logic [IW-1:0] exp_idx);
    exp_t e;
    logic is_wr;
    is_wr = (code == 2'b10) || (code == 2'b11);
    op_valid = 1'b1; op_code = code; cp0_index = idx; cp0_entry = ent;
    #1;
    check("stall_T", 128'(stall_o), 128'd1);
    e.kind = is_wr ? K_WR : (code == 2'b00 ? K_P : K_R);
    e.data = is_wr ? 128'({exp_idx, ent}) : (code == 2'b00 ? 128'(res) : 128'(rd));
    exp_q.push_back(e);
    step();
    cp0_entry = ~ent;
    flush = 1'b1;
    check("stall_T1", 128'(stall_o), 128'd1);
    check("tlbwi_T1", 128'(tlbwi), 128'(is_wr));
    check("tlbp_T1", 128'(tlbp), 128'(code == 2'b00));
    check("config_T1", 128'(tlb_config), 128'({exp_idx, ent}));
    if (code == 2'b01) check("rd_index_T1", 128'(tlb_rd_index), 128'(exp_idx));
    step();
    tlbp_result = res; tlb_rd_data = rd;
    check("stall_T2", 128'(stall_o), 128'd1);
    check("tlbwi_T2", 128'(tlbwi | tlbp), 128'd0);
    step();
    op_valid = 1'b0; tlbp_result = '0; tlb_rd_data = '0;
    #1;
    check("stall_T3", 128'(stall_o), 128'd0);
    check("index_we_T3", 128'(index_we), 128'(code == 2'b00));
    check("entry_we_T3", 128'(entry_we), 128'(code == 2'b01));
    step();
    flush = 1'b0;
    check("wb_T4", 128'({index_we, entry_we, tlbwi}), 128'd0);
  endtask

  localparam logic [EW-1:0] ENT_E = {22'h2a5b1, 64'h0123_4567_89ab_cdef};
  localparam logic [EW-1:0] ENT_D = {22'h15c3e, 64'hfeed_beef_cafe_f00d};
  localparam logic [EW-1:0] ENT_W = {22'h3ffff, 64'h5555_aaaa_0f0f_f0f0};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_strobes", 128'({tlbwi, tlbp, index_we, entry_we, stall_o}), 128'd0);
    check("rst_config", 128'(tlb_config), 128'd0);
    check("rst_outputs", 128'({tlb_rd_index, probe_index_o, entry_o}), 128'd0);
    check("rst_random", 128'(random_o), 128'(N - 1));
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("random_count", 128'(random_o), 128'(i <= 15 ? 15 - i : 31 - i));
      check("idle_strobes", 128'({tlbwi, tlbp, index_we, entry_we, stall_o}), 128'd0);
      step();
    end

    run_op(2'b10, 4'd5, ENT_E, 32'h0, '0, 4'd5);
    run_op(2'b00, 4'd7, ENT_D, 32'h8000_0000, '0, 4'd7);
    run_op(2'b00, 4'd2, ENT_E, 32'h0000_000b, '0, 4'd2);
    run_op(2'b01, 4'd9, ENT_E, 32'h0, ENT_D, 4'd9);

    for (int k = 0; k < 40 && random_o !== 4'd3; k++) step();
    check("wait_r3", 128'(random_o), 128'd3);
    cp0_wired = 4'd12; cp0_wired_we = 1'b1;
    step();
    cp0_wired_we = 1'b0;
    check("wired_r15", 128'(random_o), 128'd15);
    step(); check("wired_r14", 128'(random_o), 128'd14);
    step(); check("wired_r13", 128'(random_o), 128'd13);
    step(); check("wired_r12", 128'(random_o), 128'd12);
    step(); check("wired_wrap", 128'(random_o), 128'd15);
    for (int k = 0; k < 40 && random_o !== 4'd13; k++) step();
    check("wait_r13", 128'(random_o), 128'd13);
    run_op(2'b11, 4'd2, ENT_W, 32'h0, '0, 4'd13);

    cp0_wired = 4'd15;
    step(); step();
    check("wired_max_hold", 128'(random_o), 128'd15);
    run_op(2'b11, 4'd1, ENT_E, 32'h0, '0, 4'd15);
    cp0_wired = 4'd0;

    op_valid = 1'b1; op_code = 2'b10; flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("flush_stall", 128'(stall_o), 128'd0);
      step();
      check("flush_noexec", 128'({tlbwi, tlbp}), 128'd0);
    end
    op_valid = 1'b0; flush = 1'b0;
    step();

    op_valid = 1'b1; op_code = 2'b00; cp0_index = 4'd4;
    step();
    step();
    rst = 1'b1; op_valid = 1'b0;
    #1;
    check("rst_mid_we", 128'({index_we, tlbp, stall_o}), 128'd0);
    check("rst_mid_random", 128'(random_o), 128'd15);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("rst_mid_nowb", 128'({index_we, entry_we, stall_o}), 128'd0);
      step();
    end

    check("sb_drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
